// File: rtl/lc3_dmem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : lc3_dmem_pkg                                                 |
// | Purpose   : Shared types and constants for the LC3 data-memory responder |
// |             (FSM state encoding, bus widths, latency bounds).            |
// | Ports     : n/a (package)                                                |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package lc3_dmem_pkg;

  localparam int DMEM_DATA_W      = 16;
  localparam int DMEM_ADDR_W      = 16;
  localparam int DMEM_MAX_LATENCY = 15;
  // Wide enough to hold LATENCY-1 for the largest legal LATENCY.
  localparam int DMEM_CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  // Request as captured on the accept edge.
  typedef struct packed {
    logic                   rd;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] din;
  } dmem_req_t;

endpackage : lc3_dmem_pkg
`default_nettype wire

// File: rtl/lc3_dmem_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : lc3_dmem_responder_if                                        |
// | Purpose   : DMem_* bus between the LC3 MemAccess stage (master) and the  |
// |             data-memory responder (slave).                               |
// | Signals   : DMem_en/rd/addr/din  master -> slave request                 |
// |             DMem_dout/ready/err  slave -> master response                |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface lc3_dmem_responder_if;
  import lc3_dmem_pkg::*;

  logic                   DMem_en;
  logic                   DMem_rd;
  logic [DMEM_ADDR_W-1:0] DMem_addr;
  logic [DMEM_DATA_W-1:0] DMem_din;
  logic [DMEM_DATA_W-1:0] DMem_dout;
  logic                   DMem_ready;
  logic                   DMem_err;

  modport master (
    output DMem_en, DMem_rd, DMem_addr, DMem_din,
    input  DMem_dout, DMem_ready, DMem_err
  );

  modport slave (
    input  DMem_en, DMem_rd, DMem_addr, DMem_din,
    output DMem_dout, DMem_ready, DMem_err
  );

endinterface : lc3_dmem_responder_if
`default_nettype wire

// File: rtl/lc3_dmem_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : lc3_dmem_array                                               |
// | Purpose   : 2**ADDR_W x 16-bit word storage. Synchronous write, read     |
// |             data registered under a read enable, synchronous clear of    |
// |             every word and of the read register on reset.                |
// | Ports     : clock, reset        clock / sync active-high reset           |
// |             we_i                write enable (writes wdata_i @ addr_i)   |
// |             re_i, rzero_i       read enable; rzero_i loads 0 instead of  |
// |                                 the array word                           |
// |             addr_i, wdata_i     shared word index / write data           |
// |             rdata_o             registered read data (holds between re)  |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module lc3_dmem_array
  import lc3_dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   we_i,
  input  logic                   re_i,
  input  logic                   rzero_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [DMEM_DATA_W-1:0] wdata_i,
  output logic [DMEM_DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DMEM_DATA_W-1:0] mem_q [DEPTH];
  logic [DMEM_DATA_W-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // The read register doubles as the responder's DMem_dout holding register:
  // it only moves when a read completes, so it keeps the last read value.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rzero_i ? '0 : mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : lc3_dmem_array
`default_nettype wire

// File: rtl/lc3_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : lc3_dmem_responder                                           |
// | Purpose   : Data-memory responder for the LC3 MemAccess stage. Accepts   |
// |             one read/write on the DMem_* bus, completes it LATENCY edges |
// |             later and pulses DMem_ready (with DMem_err when the address  |
// |             is outside the 2**ADDR_W word array).                        |
// | Params    : ADDR_W  (1..16) array index width                            |
// |             LATENCY (1..15) accept edge to completion edge               |
// | Ports     : clock, reset   clock / sync active-high reset                 |
// |             bus (slave)    DMem_en/rd/addr/din in,                        |
// |                            DMem_dout/ready/err out                        |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module lc3_dmem_responder
  import lc3_dmem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  lc3_dmem_responder_if.slave  bus
);

  localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = DMEM_CNT_W'(LATENCY - 1);

  dmem_state_e           state_q, state_d;
  logic [DMEM_CNT_W-1:0] cnt_q,   cnt_d;
  dmem_req_t             req_q,   req_d;

  logic                  oor;
  logic                  access;
  logic                  mem_we;
  logic                  mem_re;
  logic                  ready;
  logic                  err;
  logic [DMEM_DATA_W-1:0] rdata;

  // Any set bit above the index field puts the address out of range. With
  // ADDR_W=16 the shift clears every bit, so nothing is ever out of range.
  assign oor = (req_q.addr >> ADDR_W) != '0;

  // --------------------------------------------------------------------
  // State register (FSM state plus the counter and latched request)
  // --------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // --------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      // DONE accepts exactly like IDLE so back-to-back requests cost only
      // the single completion cycle.
      IDLE, DONE: begin
        if (bus.DMem_en) begin
          state_d    = BUSY;
          cnt_d      = CNT_LOAD;
          req_d.rd   = bus.DMem_rd;
          req_d.addr = bus.DMem_addr;
          req_d.din  = bus.DMem_din;
        end else begin
          state_d = IDLE;
        end
      end
      // DMem_en is deliberately not looked at here: requests arriving while
      // busy are dropped without trace.
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------
  // Output / control decode
  // --------------------------------------------------------------------
  always_comb begin
    access = 1'b0;
    mem_we = 1'b0;
    mem_re = 1'b0;
    ready  = 1'b0;
    err    = 1'b0;
    case (state_q)
      BUSY: begin
        // The edge that ends the cnt==0 BUSY cycle performs the access.
        access = (cnt_q == '0);
        mem_we = access && !req_q.rd && !oor;
        mem_re = access &&  req_q.rd;
      end
      DONE: begin
        // req_q still holds the completed request throughout DONE.
        ready = 1'b1;
        err   = oor;
      end
      default: begin
        access = 1'b0;
      end
    endcase
  end

  lc3_dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .rzero_i (oor),
    .addr_i  (req_q.addr[ADDR_W-1:0]),
    .wdata_i (req_q.din),
    .rdata_o (rdata)
  );

  assign bus.DMem_dout  = rdata;
  assign bus.DMem_ready = ready;
  assign bus.DMem_err   = err;

endmodule : lc3_dmem_responder
`default_nettype wire

// File: tb/tb_lc3_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_lc3_dmem_responder                                        |
// | Purpose   : Scoreboard bench for lc3_dmem_responder. Three instances     |
// |             (LATENCY 3, 1, 4; ADDR_W 8) share clock and reset. Requests  |
// |             push the expected completion (cycle, dout, err) into a       |
// |             per-instance queue; a negedge monitor pops on DMem_ready.    |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_lc3_dmem_responder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic mon_en = 1'b0;
  int unsigned cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    logic [15:0] dout;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks   = 0;
  int failures = 0;

  lc3_dmem_responder_if if3 ();
  lc3_dmem_responder_if if1 ();
  lc3_dmem_responder_if if4 ();

  lc3_dmem_responder #(.ADDR_W(8), .LATENCY(3)) u_lat3 (.clock(clock), .reset(reset), .bus(if3.slave));
  lc3_dmem_responder #(.ADDR_W(8), .LATENCY(1)) u_lat1 (.clock(clock), .reset(reset), .bus(if1.slave));
  lc3_dmem_responder #(.ADDR_W(8), .LATENCY(4)) u_lat4 (.clock(clock), .reset(reset), .bus(if4.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input exp_t e);
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int id, input logic rdy, input logic [15:0] dout, input logic err);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (rdy === 1'b1) begin
      case (id)
        0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
        checks++;
        failures++;
        $display("FAIL spurious_ready dut%0d: got ready=1 at cycle %0d expected no pending response", id, cyc);
      end else begin
        chk($sformatf("ready_cycle dut%0d", id), cyc, e.due);
        chk($sformatf("dout dut%0d", id), {16'h0, dout}, {16'h0, e.dout});
        chk($sformatf("err dut%0d", id), {31'h0, err}, {31'h0, e.err});
      end
    end else begin
      chk($sformatf("err_without_ready dut%0d", id), {31'h0, err}, 32'h0);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      mon(0, if3.DMem_ready, if3.DMem_dout, if3.DMem_err);
      mon(1, if1.DMem_ready, if1.DMem_dout, if1.DMem_err);
      mon(2, if4.DMem_ready, if4.DMem_dout, if4.DMem_err);
    end
  end

  // One request, issued from a negedge; returns at the negedge inside DONE.
  task automatic req(input virtual lc3_dmem_responder_if vif, input int id, input int lat,
                     input logic rd, input logic [15:0] addr, input logic [15:0] din,
                     input logic [15:0] exp_dout, input logic exp_err);
    exp_t e;
    @(negedge clock);
    vif.DMem_en   = 1'b1;
    vif.DMem_rd   = rd;
    vif.DMem_addr = addr;
    vif.DMem_din  = din;
    e.due  = cyc + 1 + lat;
    e.dout = exp_dout;
    e.err  = exp_err;
    push(id, e);
    @(negedge clock);
    vif.DMem_en = 1'b0;
    repeat (lat) @(negedge clock);
  endtask

  task automatic idle_bus(input virtual lc3_dmem_responder_if vif);
    vif.DMem_en   = 1'b0;
    vif.DMem_rd   = 1'b0;
    vif.DMem_addr = 16'h0;
    vif.DMem_din  = 16'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    idle_bus(if3);
    idle_bus(if1);
    idle_bus(if4);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Reset state
    chk("rst_dout3",  {16'h0, if3.DMem_dout}, 32'h0);
    chk("rst_ready3", {31'h0, if3.DMem_ready}, 32'h0);
    chk("rst_err3",   {31'h0, if3.DMem_err}, 32'h0);
    chk("rst_dout1",  {16'h0, if1.DMem_dout}, 32'h0);
    chk("rst_ready4", {31'h0, if4.DMem_ready}, 32'h0);

    // LATENCY=3 instance: basic read/write and out-of-range
    req(if3, 0, 3, 1'b1, 16'h0005, 16'h0000, 16'h0000, 1'b0);
    req(if3, 0, 3, 1'b0, 16'h0012, 16'hBEEF, 16'h0000, 1'b0);
    req(if3, 0, 3, 1'b1, 16'h0012, 16'h0000, 16'hBEEF, 1'b0);
    req(if3, 0, 3, 1'b0, 16'h0100, 16'h1234, 16'hBEEF, 1'b1);
    req(if3, 0, 3, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    req(if3, 0, 3, 1'b1, 16'h0012, 16'h0000, 16'hBEEF, 1'b0);
    req(if3, 0, 3, 1'b1, 16'h0100, 16'h0000, 16'h0000, 1'b1);

    // Busy ignore: stray write strobe during BUSY must vanish
    @(negedge clock);
    if3.DMem_en = 1'b1; if3.DMem_rd = 1'b1; if3.DMem_addr = 16'h0012; if3.DMem_din = 16'h0;
    e.due = cyc + 1 + 3; e.dout = 16'hBEEF; e.err = 1'b0;
    push(0, e);
    @(negedge clock);
    if3.DMem_en = 1'b1; if3.DMem_rd = 1'b0; if3.DMem_addr = 16'h0003; if3.DMem_din = 16'hFFFF;
    @(negedge clock);
    if3.DMem_en = 1'b0;
    repeat (3) @(negedge clock);
    req(if3, 0, 3, 1'b1, 16'h0003, 16'h0000, 16'h0000, 1'b0);

    // LATENCY=1 instance: preload, then back-to-back reads with en held
    req(if1, 1, 1, 1'b0, 16'h0001, 16'h00A1, 16'h0000, 1'b0);
    req(if1, 1, 1, 1'b0, 16'h0002, 16'h00A2, 16'h0000, 1'b0);
    @(negedge clock);
    if1.DMem_en = 1'b1; if1.DMem_rd = 1'b1; if1.DMem_addr = 16'h0001;
    e.due = cyc + 2; e.dout = 16'h00A1; e.err = 1'b0;
    push(1, e);
    @(negedge clock);
    @(negedge clock);
    if1.DMem_addr = 16'h0002;
    e.due = cyc + 2; e.dout = 16'h00A2; e.err = 1'b0;
    push(1, e);
    @(negedge clock);
    if1.DMem_en = 1'b0;
    repeat (2) @(negedge clock);

    // LATENCY=4 instance: establish nonzero dout, then reset mid-BUSY
    req(if4, 2, 4, 1'b0, 16'h0007, 16'h1111, 16'h0000, 1'b0);
    req(if4, 2, 4, 1'b1, 16'h0007, 16'h0000, 16'h1111, 1'b0);
    @(negedge clock);
    if4.DMem_en = 1'b1; if4.DMem_rd = 1'b0; if4.DMem_addr = 16'h0004; if4.DMem_din = 16'h5555;
    @(negedge clock);
    if4.DMem_en = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_dout4",  {16'h0, if4.DMem_dout}, 32'h0);
    chk("midrst_ready4", {31'h0, if4.DMem_ready}, 32'h0);
    repeat (4) @(negedge clock);
    req(if4, 2, 4, 1'b1, 16'h0004, 16'h0000, 16'h0000, 1'b0);
    req(if4, 2, 4, 1'b1, 16'h0007, 16'h0000, 16'h0000, 1'b0);
    repeat (3) @(negedge clock);

    // Every pushed response must have been observed
    chk("pending_dut0", q0.size(), 32'h0);
    chk("pending_dut1", q1.size(), 32'h0);
    chk("pending_dut2", q2.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_lc3_dmem_responder
`default_nettype wire
